// File: rtl/counter_sequencer.sv
// Push-button driven sequencer for the 4-bit board counter: synchronizes and
// debounces the key, then single-steps or free-runs a modulo up/down count.
module counter_sequencer #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 16,
  parameter int PRESCALE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_n,
  input  logic             auto,
  input  logic             dir_up,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             running,
  output logic             press
);

  localparam int DBW = $clog2(DEBOUNCE);
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE - 1);
  localparam logic [PSW-1:0] PSC_LAST = PSW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_STEP,
    ST_RUN
  } state_t;

  logic             sync1_q, sync1_d;
  logic             key_s_q, key_s_d;
  logic             stable_q, stable_d;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic             press_q, press_d;
  state_t           state_q, state_d;
  logic [PSW-1:0]   psc_q, psc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             running_q, running_d;
  logic             step_en;

  // Returns {wrapped, next_count} for one modulo step; wrap sets tc.
  function automatic logic [WIDTH:0] step_fn(input logic [WIDTH-1:0] cnt,
                                             input logic [WIDTH-1:0] lim,
                                             input logic             up);
    logic [WIDTH:0] r;
    if (up) begin
      r = (cnt >= lim) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, cnt + 1'b1};
    end else begin
      r = (cnt == '0) ? {1'b1, lim} : {1'b0, cnt - 1'b1};
    end
    return r;
  endfunction

  // Synchronizer and debounce: level changes only after DEBOUNCE differing samples.
  always_comb begin
    sync1_d  = key_n;
    key_s_d  = sync1_q;
    stable_d = stable_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (key_s_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = key_s_q;
        press_d  = ~key_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Sequencer FSM and count update; load overrides any step in the same cycle.
  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    step_en = 1'b0;
    count_d = count_q;
    tc_d    = 1'b0;
    unique case (state_q)
      ST_STOP: begin
        if (press_q) begin
          if (auto) begin
            state_d = ST_RUN;
            psc_d   = '0;
          end else begin
            state_d = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        step_en = 1'b1;
        state_d = ST_STOP;
      end
      ST_RUN: begin
        if (psc_q == PSC_LAST) begin
          step_en = 1'b1;
          psc_d   = '0;
        end else begin
          psc_d = psc_q + 1'b1;
        end
        if (press_q || !auto) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
    if (load) begin
      count_d = load_val;
    end else if (step_en) begin
      {tc_d, count_d} = step_fn(count_q, limit, dir_up);
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      key_s_q   <= 1'b1;
      stable_q  <= 1'b1;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
      state_q   <= ST_STOP;
      psc_q     <= '0;
      count_q   <= '0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      key_s_q   <= key_s_d;
      stable_q  <= stable_d;
      db_cnt_q  <= db_cnt_d;
      press_q   <= press_d;
      state_q   <= state_d;
      psc_q     <= psc_d;
      count_q   <= count_d;
      tc_q      <= tc_d;
      running_q <= running_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign running = running_q;
  assign press   = press_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: vector table, directed corner
// sequences and a randomized run against a cycle-level reference model.
module tb_counter_sequencer;

  localparam int W   = 4;
  localparam int DEB = 16;
  localparam int PRE = 8;

  logic         clk;
  logic         reset;
  logic         key_n;
  logic         auto;
  logic         dir_up;
  logic [W-1:0] limit;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc;
  logic         running;
  logic         press;

  counter_sequencer #(.WIDTH(W), .DEBOUNCE(DEB), .PRESCALE(PRE)) dut (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n),
    .auto    (auto),
    .dir_up  (dir_up),
    .limit   (limit),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .tc      (tc),
    .running (running),
    .press   (press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int press_seen = 0;
  int tc_seen    = 0;

  int         chg_cyc[$];
  logic [W-1:0] chg_val[$];
  logic       chg_tc[$];
  logic [W-1:0] prev_count = '0;

  // Reference model: key history, debounce window, run/step flags and count.
  logic [W-1:0] m_count = '0;
  bit m_tc = 0, m_run = 0, m_step_due = 0, m_press = 0, m_stable = 1;
  bit m_k1 = 1, m_k2 = 1;
  int m_phase = 0;
  bit m_ksq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    bit ks, old_press, step, all_diff;
    if (reset) begin
      m_count = '0; m_tc = 0; m_run = 0; m_step_due = 0; m_press = 0;
      m_stable = 1; m_k1 = 1; m_k2 = 1; m_phase = 0;
      m_ksq.delete();
      return;
    end
    ks   = m_k2;
    m_k2 = m_k1;
    m_k1 = key_n;
    old_press = m_press;
    m_press   = 0;
    m_ksq.push_back(ks);
    if (m_ksq.size() > DEB) void'(m_ksq.pop_front());
    all_diff = (m_ksq.size() == DEB);
    foreach (m_ksq[i]) if (m_ksq[i] == m_stable) all_diff = 0;
    if (all_diff) begin
      m_stable = ~m_stable;
      m_press  = ~m_stable;
    end
    step = 0;
    if (m_step_due) begin
      step = 1;
      m_step_due = 0;
    end else if (m_run) begin
      if (m_phase == PRE - 1) begin
        step = 1;
        m_phase = 0;
      end else begin
        m_phase++;
      end
      if (old_press || !auto) m_run = 0;
    end else if (old_press) begin
      if (auto) begin
        m_run = 1;
        m_phase = 0;
      end else begin
        m_step_due = 1;
      end
    end
    m_tc = 0;
    if (load) begin
      m_count = load_val;
    end else if (step) begin
      if (dir_up) begin
        if (m_count >= limit) begin m_count = '0; m_tc = 1; end
        else m_count = m_count + 1'b1;
      end else begin
        if (m_count == '0) begin m_count = limit; m_tc = 1; end
        else m_count = m_count - 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("model", 32'({count, tc, running, press}), 32'({m_count, m_tc, m_run, m_press}));
    if (press === 1'b1) press_seen++;
    if (tc === 1'b1) tc_seen++;
    if (count !== prev_count) begin
      chg_cyc.push_back(cyc);
      chg_val.push_back(count);
      chg_tc.push_back(tc);
    end
    prev_count = count;
  endtask

  task automatic do_press(output int lat);
    lat = -1;
    key_n = 1'b0;
    for (int i = 1; i <= DEB + 6; i++) begin
      tick();
      if (press === 1'b1 && lat < 0) lat = i;
    end
    key_n = 1'b1;
    repeat (DEB + 6) tick();
  endtask

  typedef struct {
    logic         rst;
    logic         ld;
    logic [W-1:0] ldv;
    logic [W-1:0] ecount;
    logic         etc;
    logic         erun;
    logic         epress;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, n, p0, c0, dur;

    vecs[0] = '{1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 4'd12, 4'd12, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 4'd0,  4'd12, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 4'd7,  4'd0,  1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 4'd3,  4'd3,  1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 4'd9,  4'd3,  1'b0, 1'b0, 1'b0};

    reset = 1'b1; key_n = 1'b1; auto = 1'b0; dir_up = 1'b1;
    limit = 4'd9; load = 1'b0; load_val = '0;

    for (int i = 0; i < 7; i++) begin
      reset = vecs[i].rst; load = vecs[i].ld; load_val = vecs[i].ldv;
      tick();
      check("vec", 32'({count, tc, running, press}),
            32'({vecs[i].ecount, vecs[i].etc, vecs[i].erun, vecs[i].epress}));
    end

    // Reset, then idle with the key released.
    reset = 1'b1; load = 1'b0; tick();
    reset = 1'b0;
    repeat (100) tick();
    check("idle", 32'({count, tc, running, press}), 32'd0);

    // Step mode, eleven presses through a 0..9 range.
    tc_seen = 0;
    for (int i = 1; i <= 11; i++) begin
      do_press(lat);
      check("press_latency", lat, DEB + 2);
      check("step_count", 32'(count), i % 10);
    end
    check("step_tc_count", tc_seen, 1);

    // Short glitches must be rejected; a long stable low is one press.
    press_seen = 0;
    c0 = int'(count);
    for (int i = 0; i < 20; i++) begin
      key_n = 1'b0; repeat (5) tick();
      key_n = 1'b1; repeat (5) tick();
    end
    check("glitch_press", press_seen, 0);
    check("glitch_count", 32'(count), c0);
    key_n = 1'b0; repeat (40) tick();
    check("long_low_press", press_seen, 1);
    key_n = 1'b1; repeat (DEB + 6) tick();
    check("release_press", press_seen, 1);

    // Run mode counting down through a 0..5 range.
    load = 1'b1; load_val = '0; tick(); load = 1'b0;
    auto = 1'b1; dir_up = 1'b0; limit = 4'd5;
    chg_cyc.delete(); chg_val.delete(); chg_tc.delete();
    do_press(lat);
    check("run_press_latency", lat, DEB + 2);
    repeat (20) tick();
    check("run_running", 32'(running), 1);
    n = chg_val.size();
    check("run_nsteps_ok", 32'(n >= 4), 1);
    if (n > 0) begin
      check("run_first_val", 32'(chg_val[0]), 5);
      check("run_first_tc", 32'(chg_tc[0]), 1);
    end
    for (int k = 1; k < n; k++) begin
      check("run_val", 32'(chg_val[k]), 5 - k);
      check("run_gap", chg_cyc[k] - chg_cyc[k-1], PRE);
      check("run_tc", 32'(chg_tc[k]), 0);
    end
    do_press(lat);
    c0 = int'(count);
    repeat (30) tick();
    check("stop_frozen", 32'(count), c0);
    check("stop_running", 32'(running), 0);

    // Load coinciding with a run step: load wins, tc suppressed.
    dir_up = 1'b1; limit = 4'd9;
    do_press(lat);
    for (int i = 0; i < PRE + 4 && !(m_run && m_phase == PRE - 1); i++) tick();
    check("load_sync_found", 32'(m_run && m_phase == PRE - 1), 1);
    load = 1'b1; load_val = 4'd12; tick(); load = 1'b0;
    check("load_over_step_count", 32'(count), 12);
    check("load_over_step_tc", 32'(tc), 0);
    repeat (PRE) tick();
    check("after_load_wrap_count", 32'(count), 0);
    check("after_load_wrap_tc", 32'(tc), 1);

    // Reset during run with a key held low across it.
    key_n = 1'b0; repeat (3) tick();
    load = 1'b1; load_val = 4'd7; tick(); load = 1'b0;
    check("pre_reset_count", 32'(count), 7);
    check("pre_reset_running", 32'(running), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("reset_mid_run", 32'({count, tc, running, press}), 32'd0);
    lat = -1;
    for (int i = 1; i <= DEB + 6; i++) begin
      tick();
      if (press === 1'b1 && lat < 0) lat = i;
    end
    check("held_key_latency", lat, DEB + 2);
    key_n = 1'b1; repeat (DEB + 6) tick();

    // Randomized operation against the model.
    dur = 1;
    for (int i = 0; i < 4000; i++) begin
      dur--;
      if (dur <= 0) begin
        key_n = ~key_n;
        dur = int'($urandom_range(1, 40));
      end
      if ($urandom_range(0, 63) == 0) auto = ~auto;
      if ($urandom_range(0, 31) == 0) dir_up = ~dir_up;
      if ($urandom_range(0, 31) == 0) limit = 4'($urandom_range(0, 15));
      load = ($urandom_range(0, 49) == 0);
      load_val = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; load = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Synchronous sequencer that drives the team's 4-bit board counter from a single push button instead of clocking flip-flops directly from the key. It debounces the active-low key, then either single-steps the count per press or free-runs it from a prescaled tick. Direction, modulus and preload are configurable. Outputs feed the green LED bank and a terminal-count pulse for cascading.

Parameters:
WIDTH, 4, count width in bits
DEBOUNCE, 16, consecutive stable cycles needed to accept a key level change (>=2)
PRESCALE, 8, clock cycles per count step in RUN state (>=1)

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
key_n  input  1  raw push button, active-low, asynchronous to clk, may bounce
auto  input  1  0 = step mode (each press = one step); 1 = run mode (press toggles run/stop)
dir_up  input  1  1 = count up, 0 = count down
limit  input  WIDTH  modulus top; count range is 0..limit
load  input  1  synchronous preload strobe
load_val  input  WIDTH  preload value
count  output  WIDTH  current count, registered
tc  output  1  one-cycle pulse on wrap
running  output  1  high while in RUN
press  output  1  one-cycle debounced press pulse

Behaviour:
- Reset, synchronous, active-high, is dominant over all other inputs. It sets:
  - count=0, tc=0, running=0, press=0, state=STOP
  - both synchronizer flops=1 and the debounced level=1 (released)
  - debounce counter=0, prescaler=0
- Synchronizer: key_n passes through 2 flops, giving key_s.
- Debounce:
  - A counter increments while key_s != stable level and clears when they are equal.
  - When the counter reaches DEBOUNCE-1 with key_s still differing, the stable level takes key_s and the counter clears.
  - press is a registered 1-cycle pulse on a stable 1->0 transition only. Release generates nothing.
  - A clean key_n fall produces press exactly DEBOUNCE+2 clock edges after the first edge that samples key_n low.
  - Any bounce shorter than DEBOUNCE cycles produces no press.
- FSM states: STOP, STEP, RUN.
  - STOP: count holds. On press: auto=0 -> STEP; auto=1 -> RUN, prescaler cleared.
  - STEP: exactly one cycle. Applies one count step, then returns to STOP unconditionally. A press arriving in STEP is ignored.
  - RUN: prescaler counts 0..PRESCALE-1. On PRESCALE-1 it applies one step and wraps to 0.
  - RUN -> STOP on press, or on auto=0, sampled each cycle. Press wins if both occur; the result is the same either way. Prescaler holds its value in STOP.
  - running = (state==RUN), registered with the state.
- Step rule, evaluated with the current dir_up and limit:
  - Up: if count >= limit, count becomes 0 and tc=1; else count+1.
  - Down: if count == 0, count becomes limit and tc=1; else count-1.
  - If count > limit while counting down, count-1 is applied normally; there is no clamp.
  - limit=0: count stays 0 and tc pulses on every step.
  - tc is a registered pulse, high in the cycle count shows the wrapped value, and 0 otherwise.
- Load:
  - load=1 sets count=load_val the next cycle, with no clamp to limit.
  - Load has priority over a coincident step; that step is dropped and tc stays 0.
  - Load does not change state or the prescaler.
- Changes to limit, dir_up and auto take effect at the next step evaluation. There is no latching.
- Reset asserted mid-RUN or mid-debounce returns to the reset values in the next cycle. A key held low through reset release must satisfy DEBOUNCE again before it produces a press.

Test Plan:
- Reset then idle, key_n=1 -> count=0, running=0, tc=0, press=0 for 100 cycles.
- auto=0, dir_up=1, limit=9, 11 clean presses -> count goes 1..9, 0, 1; tc pulses once, on the 9->0 step. Each press appears DEBOUNCE+2 cycles after key_n falls.
- key_n bursts of 5-cycle low/high glitches for 200 cycles, DEBOUNCE=16 -> no press, count unchanged. A following 40-cycle stable low gives exactly one press.
- auto=1, dir_up=0, limit=5, count=0, one press -> RUN; count reads 5, 4, 3, ... stepping every 8 cycles, with tc on the 0->5 step. A second press -> STOP, count frozen.
- In RUN, assert load with load_val=12 in the same cycle as a prescaler step, limit=9, dir_up=1 -> count=12, tc=0. The next step gives count=0 with tc=1.
- Assert reset for 1 cycle during RUN with count=7 -> the next cycle shows count=0, running=0, state STOP. A key held low across reset gives press only after DEBOUNCE+2 further cycles.
